path_tracer: RTL

- Consumer at the read end of the maze path store.
- After the solver signals completion, it drains the stored location sequence in FIFO order via pop/run.
- It converts each consecutive pair of packed locations into a 2-bit move direction and presents the directions on a valid/ready stream to the result/display logic.
- It also reports the path length in moves, a finish pulse, and a sticky error for non-adjacent steps.

---
 rtl/path_tracer.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/path_tracer.sv
// Drains the maze path store after the solver finishes and turns each pair of
// consecutive locations into a move direction on a valid/ready stream.
module path_tracer #(
  parameter int unsigned COORD_W = 4,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 emp_i,
  input  logic [2*COORD_W-1:0] loc_i,
  output logic                 pop_o,
  output logic                 run_o,
  output logic [1:0]           dir_o,
  output logic                 dir_valid_o,
  input  logic                 dir_ready_i,
  output logic [CNT_W-1:0]     len_o,
  output logic                 busy_o,
  output logic                 finish_o,
  output logic                 err_o
);

  localparam int unsigned LOC_W = 2 * COORD_W;
  localparam int unsigned EXT_W = COORD_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_CHECK,
    S_POP,
    S_LATCH,
    S_EMIT,
    S_DONE,
    S_ERR
  } stateT;

  stateT              state;
  stateT              stateNext;
  logic [LOC_W-1:0]   prevLoc;
  logic [LOC_W-1:0]   prevNext;
  logic               haveFirst;
  logic               firstNext;
  logic [1:0]         dirNext;
  logic [CNT_W-1:0]   lenNext;
  logic               errNext;

  logic [COORD_W-1:0] xCur;
  logic [COORD_W-1:0] yCur;
  logic [COORD_W-1:0] xPrev;
  logic [COORD_W-1:0] yPrev;
  logic               xUp;
  logic               xDown;
  logic               yUp;
  logic               yDown;
  logic               stepOk;
  logic [1:0]         stepDir;

  // Adjacency: compare in one extra bit so 15->0 never looks like +1.
  always_comb begin
    xCur    = loc_i[LOC_W-1:COORD_W];
    yCur    = loc_i[COORD_W-1:0];
    xPrev   = prevLoc[LOC_W-1:COORD_W];
    yPrev   = prevLoc[COORD_W-1:0];
    xUp     = (EXT_W'(xCur) == EXT_W'(xPrev) + EXT_W'(1));
    xDown   = (EXT_W'(xCur) + EXT_W'(1) == EXT_W'(xPrev));
    yUp     = (EXT_W'(yCur) == EXT_W'(yPrev) + EXT_W'(1));
    yDown   = (EXT_W'(yCur) + EXT_W'(1) == EXT_W'(yPrev));
    stepOk  = ((xUp || xDown) && (yCur == yPrev)) ||
              ((yUp || yDown) && (xCur == xPrev));
    if (xUp) begin
      stepDir = 2'b00;
    end else if (xDown) begin
      stepDir = 2'b01;
    end else if (yUp) begin
      stepDir = 2'b10;
    end else begin
      stepDir = 2'b11;
    end
  end

  // Next-state and next-value logic for the drain sequence.
  always_comb begin
    stateNext = state;
    prevNext  = prevLoc;
    firstNext = haveFirst;
    dirNext   = dir_o;
    lenNext   = len_o;
    errNext   = err_o;
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start_i) begin
          stateNext = S_ARM;
          lenNext   = '0;
          errNext   = 1'b0;
          firstNext = 1'b0;
        end
      end
      S_ARM:   stateNext = S_CHECK;
      S_CHECK: stateNext = emp_i ? S_DONE : S_POP;
      S_POP:   stateNext = S_LATCH;
      S_LATCH: begin
        if (!haveFirst) begin
          prevNext  = loc_i;
          firstNext = 1'b1;
          stateNext = S_CHECK;
        end else if (!stepOk) begin
          errNext   = 1'b1;
          stateNext = S_ERR;
        end else begin
          dirNext   = stepDir;
          prevNext  = loc_i;
          stateNext = S_EMIT;
        end
      end
      S_EMIT: begin
        if (dir_ready_i) begin
          if (len_o != {CNT_W{1'b1}}) begin
            lenNext = len_o + CNT_W'(1);
          end
          stateNext = S_CHECK;
        end
      end
      default: stateNext = S_IDLE;
    endcase
  end

  // State and registered outputs; outputs are decoded from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      prevLoc     <= '0;
      haveFirst   <= 1'b0;
      pop_o       <= 1'b0;
      run_o       <= 1'b0;
      dir_o       <= 2'b00;
      dir_valid_o <= 1'b0;
      len_o       <= '0;
      busy_o      <= 1'b0;
      finish_o    <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      state       <= stateNext;
      prevLoc     <= prevNext;
      haveFirst   <= firstNext;
      pop_o       <= (stateNext == S_POP);
      run_o       <= (stateNext == S_POP);
      dir_o       <= dirNext;
      dir_valid_o <= (stateNext == S_EMIT);
      len_o       <= lenNext;
      busy_o      <= !((stateNext == S_IDLE) || (stateNext == S_DONE) ||
                       (stateNext == S_ERR));
      finish_o    <= (stateNext == S_DONE) && (state != S_DONE);
      err_o       <= errNext;
    end
  end

endmodule
